// File: rtl/sync_tdp_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_tdp_ram_pkg
// Description : Shared types and constants for the true-dual-port RAM:
//               read-during-write mode codes, sequencer state encoding and
//               the lane-width legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_tdp_ram_pkg;

    // Same-port read-during-write behaviour selected by READ_MODE.
    localparam int c_read_first  = 0;
    localparam int c_write_first = 1;

    // Clear sequencer states.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // A word must split into a whole number of byte-enable lanes.
    function automatic bit lanes_legal(input int data_width, input int byte_width);
        return (byte_width > 0) && ((data_width % byte_width) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_tdp_ram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sync_tdp_ram_rd_pipe
// Description : Per-port read result pipeline, depth 1 + OUT_REG. Data only
//               advances with a valid result, so the output holds its last
//               value while no read completes. Reset flushes everything.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_tdp_ram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_REG    = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_vld_s1;
    logic [DATA_WIDTH-1:0] r_data_s1;

    // First stage: capture the array read of this cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_s1  <= 1'b0;
            r_data_s1 <= '0;
        end else begin
            r_vld_s1 <= i_valid;
            if (i_valid) begin
                r_data_s1 <= i_data;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  r_vld_s2;
            logic [DATA_WIDTH-1:0] r_data_s2;

            // Optional second stage for timing; holds on idle cycles.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_vld_s2  <= 1'b0;
                    r_data_s2 <= '0;
                end else begin
                    r_vld_s2 <= r_vld_s1;
                    if (r_vld_s1) begin
                        r_data_s2 <= r_data_s1;
                    end
                end
            end

            assign o_valid = r_vld_s2;
            assign o_data  = r_data_s2;
        end else begin : g_no_out_reg
            assign o_valid = r_vld_s1;
            assign o_data  = r_data_s1;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sync_tdp_ram.sv
`default_nettype none
// ============================================================================
// Module      : sync_tdp_ram
// Description : Synchronous true-dual-port RAM with per-lane write enables,
//               selectable read-during-write mode, optional output register,
//               per-port valid, dual-write collision flag and a post-reset
//               clear sequencer that zeroes the whole array.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_tdp_ram
    import sync_tdp_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int READ_MODE      = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    output logic                             o_ready,
    input  logic                             i_en_a,
    input  logic                             i_wr_a,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_be_a,
    input  logic [ADDR_WIDTH-1:0]            i_addr_a,
    input  logic [DATA_WIDTH-1:0]            i_data_a,
    output logic [DATA_WIDTH-1:0]            o_data_a,
    output logic                             o_valid_a,
    input  logic                             i_en_b,
    input  logic                             i_wr_b,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_be_b,
    input  logic [ADDR_WIDTH-1:0]            i_addr_b,
    input  logic [DATA_WIDTH-1:0]            i_data_b,
    output logic [DATA_WIDTH-1:0]            o_data_b,
    output logic                             o_valid_b,
    output logic                             o_collision
);

    localparam int c_nb    = DATA_WIDTH / BYTE_WIDTH;
    localparam int c_depth = 1 << ADDR_WIDTH;

    generate
        if (!lanes_legal(DATA_WIDTH, BYTE_WIDTH)) begin : g_bad_lane_width
            $error("sync_tdp_ram: DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
        if ((READ_MODE != c_read_first) && (READ_MODE != c_write_first)) begin : g_bad_read_mode
            $error("sync_tdp_ram: READ_MODE must be 0 (read-first) or 1 (write-first)");
        end
    endgenerate

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [ADDR_WIDTH-1:0] w_clr_cnt_next;
    logic                  w_ready;
    logic                  w_wr_a;
    logic                  w_wr_b;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;
    logic                  r_collision;
    logic [DATA_WIDTH-1:0] r_mem [c_depth];

    // Clear sequencer next state: walk every address once, then run.
    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        case (r_state)
            ST_CLEAR: begin
                w_clr_cnt_next = r_clr_cnt + 1'b1;
                if (r_clr_cnt == {ADDR_WIDTH{1'b1}}) begin
                    w_state_next = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    // Clear sequencer state register; reset restarts the walk at address 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    // Ports are live only in RUN and outside reset.
    assign w_ready = (r_state == ST_RUN) && !i_rst;
    assign o_ready = w_ready;
    assign w_wr_a  = w_ready && i_en_a && i_wr_a;
    assign w_wr_b  = w_ready && i_en_b && i_wr_b;

    // Array write: clear word or lane writes. Port A is applied last so it
    // wins on lanes both ports enable at the same address.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_cnt] <= '0;
            end else begin
                for (int i = 0; i < c_nb; i++) begin
                    if (w_wr_b && i_be_b[i]) begin
                        r_mem[i_addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= i_data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                    if (w_wr_a && i_be_a[i]) begin
                        r_mem[i_addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= i_data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    // Read word: pre-write array contents, with own-port lanes forwarded in
    // write-first mode. The other port's write is never forwarded.
    always_comb begin
        w_rd_a = r_mem[i_addr_a];
        w_rd_b = r_mem[i_addr_b];
        if (READ_MODE == c_write_first) begin
            for (int i = 0; i < c_nb; i++) begin
                if (w_wr_a && i_be_a[i]) begin
                    w_rd_a[i*BYTE_WIDTH +: BYTE_WIDTH] = i_data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
                if (w_wr_b && i_be_b[i]) begin
                    w_rd_b[i*BYTE_WIDTH +: BYTE_WIDTH] = i_data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Collision flag: both ports write the same word with overlapping lanes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_collision <= 1'b0;
        end else begin
            r_collision <= w_wr_a && w_wr_b && (i_addr_a == i_addr_b) && ((i_be_a & i_be_b) != '0);
        end
    end

    assign o_collision = r_collision;

    sync_tdp_ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_rd_pipe_a (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (w_ready && i_en_a),
        .i_data  (w_rd_a),
        .o_valid (o_valid_a),
        .o_data  (o_data_a)
    );

    sync_tdp_ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_rd_pipe_b (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (w_ready && i_en_b),
        .i_data  (w_rd_b),
        .o_valid (o_valid_b),
        .o_data  (o_data_b)
    );

endmodule
`default_nettype wire
